// File: rtl/gate3_exerciser.sv
// Built-in exerciser for a 3-input gate cell: walks A,B,C through all 8 vectors and scores Y.
// Optional first-failure capture is enabled by defining GATE3_FIRST_FAIL_EN.
module gate3_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int GATE_FUNC     = 0,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       vec_idx
`ifdef GATE3_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [2:0]       first_fail_idx
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Codes 6 and 7 fall through to AND.
  function automatic logic expected_y(input logic a, input logic b, input logic c);
    case (GATE_FUNC)
      1:       return a | b | c;
      2:       return ~(a & b & c);
      3:       return ~(a | b | c);
      4:       return a ^ b ^ c;
      5:       return ~(a ^ b ^ c);
      default: return a & b & c;
    endcase
  endfunction

  assign mismatch = (state == CHECK) && (Y != expected_y(A, B, C));
  assign err_next = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_next = CHECK;
      end
      CHECK:  begin
        busy       = 1'b1;
        state_next = (vec_idx == 3'd7) ? DONE : SETTLE;
      end
      DONE:   begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // pass is taken from err_next so the vector-7 result is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      vec_idx        <= '0;
      {A, B, C}      <= 3'b000;
      err_cnt        <= '0;
      pass           <= 1'b0;
`ifdef GATE3_FIRST_FAIL_EN
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt            <= '0;
            vec_idx        <= '0;
            {A, B, C}      <= 3'b000;
            err_cnt        <= '0;
            pass           <= 1'b0;
`ifdef GATE3_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
`endif
          end
        end
        SETTLE: cnt <= cnt + CNT_W'(1);
        CHECK: begin
          err_cnt <= err_next;
`ifdef GATE3_FIRST_FAIL_EN
          if (mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= vec_idx;
          end
`endif
          if (vec_idx != 3'd7) begin
            vec_idx   <= vec_idx + 3'd1;
            {A, B, C} <= vec_idx + 3'd1;
            cnt       <= '0;
          end else begin
            pass <= (err_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate3_exerciser.sv
// Randomised scoreboard bench: two exercisers (AND/4-bit count, XOR/2-bit count) share one start
// and each drives a bench-controlled gate lookup table; expectations come from a truth-table model.
module tb_gate3_exerciser;

  localparam int S      = 2;
  localparam int SWEEP  = 8 * (S + 1);
  localparam int PERIOD = SWEEP + 2;

  typedef struct {
    int err;
    int pass;
    int ffi;
    int ffv;
    int done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a1, b1, c1, y1, busy1, done1, pass1;
  logic       a2, b2, c2, y2, busy2, done2, pass2;
  logic [3:0] err1;
  logic [1:0] err2;
  logic [2:0] idx1, idx2;
  logic [7:0] tab1 = 8'h80;
  logic [7:0] tab2 = 8'h96;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       q1[$];
  exp_t       q2[$];
`ifdef GATE3_FIRST_FAIL_EN
  logic       ffv1, ffv2;
  logic [2:0] ffi1, ffi2;
`endif

  assign y1 = tab1[{a1, b1, c1}];
  assign y2 = tab2[{a2, b2, c2}];

  gate3_exerciser #(.SETTLE_CYCLES(S), .GATE_FUNC(0), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a1), .B(b1), .C(c1), .Y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .vec_idx(idx1)
`ifdef GATE3_FIRST_FAIL_EN
    , .first_fail_vld(ffv1), .first_fail_idx(ffi1)
`endif
  );

  gate3_exerciser #(.SETTLE_CYCLES(S), .GATE_FUNC(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a2), .B(b2), .C(c2), .Y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .vec_idx(idx2)
`ifdef GATE3_FIRST_FAIL_EN
    , .first_fail_vld(ffv2), .first_fail_idx(ffi2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Truth of the selected gate for vector v = {A,B,C}.
  function automatic int ref_fn(input int func, input int v);
    int ones = $countones(v[2:0]);
    case (func)
      4:       return ones % 2;
      default: return (v == 7) ? 1 : 0;
    endcase
  endfunction

  function automatic exp_t build(input int func, input int w, input logic [7:0] tab, input int dc);
    exp_t e;
    int   n = 0;
    e.ffv = 0;
    e.ffi = 0;
    for (int v = 0; v < 8; v++) begin
      if (int'(tab[v]) != ref_fn(func, v)) begin
        if (n == 0) begin
          e.ffv = 1;
          e.ffi = v;
        end
        n++;
      end
    end
    e.err      = (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    e.pass     = (n == 0) ? 1 : 0;
    e.done_cyc = dc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding sweep.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) checkOutput("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        checkOutput("dut1_err_cnt", int'(err1), e.err);
        checkOutput("dut1_pass", int'(pass1), e.pass);
        checkOutput("dut1_done_cycle", cyc, e.done_cyc);
        checkOutput("dut1_final_vec", int'({idx1, a1, b1, c1}), 8'h3f);
`ifdef GATE3_FIRST_FAIL_EN
        checkOutput("dut1_ff_vld", int'(ffv1), e.ffv);
        if (e.ffv != 0) checkOutput("dut1_ff_idx", int'(ffi1), e.ffi);
`endif
      end
    end
    if (rst_n && done2) begin
      if (q2.size() == 0) checkOutput("dut2_unexpected_done", 1, 0);
      else begin
        e = q2.pop_front();
        checkOutput("dut2_err_cnt", int'(err2), e.err);
        checkOutput("dut2_pass", int'(pass2), e.pass);
        checkOutput("dut2_done_cycle", cyc, e.done_cyc);
`ifdef GATE3_FIRST_FAIL_EN
        checkOutput("dut2_ff_vld", int'(ffv2), e.ffv);
        if (e.ffv != 0) checkOutput("dut2_ff_idx", int'(ffi2), e.ffi);
`endif
      end
    end
  end

  task automatic waitDrain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 10 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      checkOutput("drain_timeout", q1.size() + q2.size(), 0);
      q1.delete();
      q2.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic makeTables(input int mode1, input int mode2);
    for (int v = 0; v < 8; v++) begin
      case (mode1)
        0:       tab1[v] = ref_fn(0, v) != 0;
        1:       tab1[v] = 1'($urandom_range(0, 1));
        default: tab1[v] = (v != 0);
      endcase
      case (mode2)
        0:       tab2[v] = ref_fn(4, v) != 0;
        1:       tab2[v] = 1'($urandom_range(0, 1));
        default: tab2[v] = 1'b0;
      endcase
    end
  endtask

  // One sweep from IDLE; optionally pokes start again mid-sweep, which must be ignored.
  task automatic applyStimulus(input int mode1, input int mode2, input bit mid_pulse);
    makeTables(mode1, mode2);
    q1.push_back(build(0, 4, tab1, cyc + 1 + SWEEP));
    q2.push_back(build(4, 2, tab2, cyc + 1 + SWEEP));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mid_pulse) begin
      repeat ($urandom_range(2, 18)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitDrain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_dut1", int'({a1, b1, c1, busy1, done1, pass1, err1, idx1}), 0);
    checkOutput("reset_dut2", int'({a2, b2, c2, busy2, done2, pass2, err2, idx2}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 0, 1'b0);
    applyStimulus(2, 2, 1'b0);
    applyStimulus(0, 0, 1'b1);
    for (int i = 0; i < 9; i++)
      applyStimulus($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    // Abort in the middle of vector 5, then a clean sweep must still pass.
    makeTables(1, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("abort_vec_idx", int'(idx1), 5);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_dut1_zero", int'({a1, b1, c1, busy1, done1, pass1, err1, idx1}), 0);
    checkOutput("abort_dut2_zero", int'({a2, b2, c2, busy2, done2, pass2, err2, idx2}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 1'b0);

    // Start held high: three back-to-back sweeps, one IDLE cycle between DONE and the next accept.
    makeTables(1, 1);
    for (int k = 0; k < 3; k++) begin
      q1.push_back(build(0, 4, tab1, cyc + 1 + SWEEP + k * PERIOD));
      q2.push_back(build(4, 2, tab2, cyc + 1 + SWEEP + k * PERIOD));
    end
    start = 1'b1;
    repeat (SWEEP + 1 + 2 * PERIOD) @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (SWEEP + 4) @(negedge clk);
    checkOutput("idle_after_hold", int'({busy1, busy2, done1, done2}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
